// File: rtl/pulse_width_tx_pkg.sv
// Shared definitions for the pulse-width serial transmitter.
// Line levels, default timings, counter width and FSM states.
package pulse_width_tx_pkg;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

    localparam int DEF_SHORT    = 4;
    localparam int DEF_LONG     = 12;
    localparam int DEF_BIT_GAP  = 2;
    localparam int DEF_BYTE_GAP = 4;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_WAIT,
        S_SPACE,
        S_MARK,
        S_TAIL,
        S_ACK
    } tx_state_e;

endpackage

// File: rtl/pulse_width_tx_pulse_len_sel.sv
// Maps a data bit to its space length minus one.
// A 1 bit is a short pulse, a 0 bit a long pulse.
module pulse_len_sel
    import pulse_width_tx_pkg::*;
#(
    parameter int SHORT = DEF_SHORT,
    parameter int LONG  = DEF_LONG
) (
    input  logic             bit_val,
    output logic [CNT_W-1:0] len_m1
);

    localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG - 1);

    // pick the preload for the space down-counter
    always_comb begin
        len_m1 = bit_val ? SHORT_M1 : LONG_M1;
    end

endmodule

// File: rtl/pulse_width_tx.sv
// Pulse-width serial byte transmitter, LSB first.
// Short space = 1, long space = 0, mark gaps between pulses.
module pulse_width_tx
    import pulse_width_tx_pkg::*;
#(
    parameter int SHORT    = DEF_SHORT,
    parameter int LONG     = DEF_LONG,
    parameter int BIT_GAP  = DEF_BIT_GAP,
    parameter int BYTE_GAP = DEF_BYTE_GAP
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_,
    input  logic [7:0] byte_in,
    output logic       rfd,
    output logic       txd
);

    if (SHORT < 1 || SHORT > 7) begin : g_bad_short
        $fatal(1, "pulse_width_tx: SHORT=%0d not in 1..7", SHORT);
    end
    if (LONG < 8 || LONG > 15) begin : g_bad_long
        $fatal(1, "pulse_width_tx: LONG=%0d not in 8..15", LONG);
    end
    if (BIT_GAP < 2 || BIT_GAP > 16) begin : g_bad_bit_gap
        $fatal(1, "pulse_width_tx: BIT_GAP=%0d not in 2..16", BIT_GAP);
    end
    if (BYTE_GAP < 4 || BYTE_GAP > 16) begin : g_bad_byte_gap
        $fatal(1, "pulse_width_tx: BYTE_GAP=%0d not in 4..16", BYTE_GAP);
    end

    localparam logic [CNT_W-1:0] BIT_GAP_M1  = CNT_W'(BIT_GAP - 1);
    localparam logic [CNT_W-1:0] BYTE_GAP_M1 = CNT_W'(BYTE_GAP - 1);

    tx_state_e        state;
    logic [7:0]       buf_q;
    logic [2:0]       nbit;
    logic [CNT_W-1:0] cnt;
    logic             sel_bit;
    logic [CNT_W-1:0] len_m1;

    // next bit to encode: fresh byte in S_WAIT, shifted buffer otherwise
    always_comb begin
        sel_bit = (state == S_WAIT) ? byte_in[0] : buf_q[0];
    end

    pulse_len_sel #(
        .SHORT (SHORT),
        .LONG  (LONG)
    ) u_len_sel (
        .bit_val (sel_bit),
        .len_m1  (len_m1)
    );

    // transmit FSM with registered line and handshake outputs
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S_WAIT;
            txd   <= MARK;
            rfd   <= 1'b1;
            buf_q <= '0;
            nbit  <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (!dav_) begin
                        buf_q <= byte_in;
                        nbit  <= '0;
                        rfd   <= 1'b0;
                        txd   <= SPACE;
                        cnt   <= len_m1;
                        state <= S_SPACE;
                    end
                end
                S_SPACE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        txd   <= MARK;
                        buf_q <= buf_q >> 1;
                        nbit  <= nbit + 3'd1;
                        if (nbit == 3'd7) begin
                            cnt   <= BYTE_GAP_M1;
                            state <= S_TAIL;
                        end else begin
                            cnt   <= BIT_GAP_M1;
                            state <= S_MARK;
                        end
                    end
                end
                S_MARK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        txd   <= SPACE;
                        cnt   <= len_m1;
                        state <= S_SPACE;
                    end
                end
                S_TAIL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (dav_) begin
                        rfd   <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_width_tx.md
Name: pulse_width_tx

Overview:
- Serial transmitter that sits directly upstream of the pulse-width byte receiver and drives its rxd line.
- Accepts one byte at a time from a producer over a dav_/rfd handshake.
- Sends the byte LSB first. Each bit is a space (0) pulse whose length encodes the value, and pulses are separated by mark (1) gaps.
- Short pulse (<8 clocks) = 1, long pulse (8..15 clocks) = 0, matching the receiver's 4-bit pulse counter.

Parameters:
- SHORT, 4: space length in clocks for bit value 1. Legal range 1..7.
- LONG, 12: space length in clocks for bit value 0. Legal range 8..15.
- BIT_GAP, 2: mark clocks between consecutive bit pulses. Minimum 2, because the receiver needs one decode cycle.
- BYTE_GAP, 4: mark clocks after the 8th pulse before the next byte may start. Minimum 4, because the receiver needs decode, sum and output cycles.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- reset_  in  1  reset, asynchronous, active-low.
- dav_  in  1  data valid from the producer, active-low.
- byte_in  in  8  byte to send; valid while dav_=0.
- rfd  out  1  ready for data, 1 = idle and able to accept a byte.
- txd  out  1  serial line to the receiver's rxd; 1 = mark, 0 = space.

Behaviour:
- Reset: asynchronous, active whenever reset_=0.
  - txd=1, rfd=1, state=S_WAIT, all counters 0.
  - A reset mid-byte truncates the pulse immediately (txd returns to mark). No recovery is attempted; the byte is lost.
- Registers:
  - BUF[7:0]: shift register, LSB sent first.
  - NBIT[2:0]: bits sent.
  - CNT[3:0]: down-counter.
  - STAR: state.
- S_WAIT: txd=1, rfd=1.
  - On an edge with dav_=0: BUF<=byte_in, NBIT<=0, rfd<=0, txd<=0.
  - CNT <= (byte_in[0] ? SHORT : LONG) - 1; go to S_SPACE.
  - Latency: txd falls on the same edge that samples dav_=0.
- S_SPACE: txd=0.
  - If CNT!=0: CNT--.
  - Else: txd<=1, BUF<=BUF>>1, NBIT<=NBIT+1, then:
    - if NBIT==7: CNT<=BYTE_GAP-1, go to S_TAIL;
    - otherwise: CNT<=BIT_GAP-1, go to S_MARK.
  - Result: txd is low for exactly SHORT or LONG clocks.
- S_MARK: txd=1.
  - If CNT!=0: CNT--.
  - Else: txd<=0, CNT <= (BUF[0] ? SHORT : LONG) - 1, go to S_SPACE.
  - Result: mark lasts exactly BIT_GAP clocks.
- S_TAIL: txd=1.
  - If CNT!=0: CNT--.
  - Else: go to S_ACK.
  - Result: mark lasts at least BYTE_GAP clocks.
- S_ACK: txd=1, rfd stays 0.
  - Wait for dav_=1, then rfd<=1 and go to S_WAIT.
  - If dav_ is already 1, this takes one clock.
  - A producer holding dav_=0 stalls here and never causes a byte to be sent twice.
- byte_in is sampled only in S_WAIT. Changes to byte_in or dav_ during transmission are ignored.
- Total line time per byte = sum of pulse lengths + 7*BIT_GAP + BYTE_GAP.
  - Defaults: 0xFF → 50 clocks, 0x00 → 114 clocks.
- Parameter violations are illegal configurations. Add a simulation-time check that reports them and stops.

Decomposition:
- Shared package holds:
  - mark=1, space=0 (line levels shared with the receiver);
  - default SHORT/LONG/BIT_GAP/BYTE_GAP;
  - the 4-bit pulse-counter width;
  - state encodings S_WAIT..S_ACK.
- One sub-module is natural: pulse_len_sel, combinational. Maps a bit value to (SHORT or LONG) - 1 as a 4-bit value, and is used in both S_WAIT and S_MARK.

Test Plan:
- Reset with dav_=1 → txd=1, rfd=1, and both stay there for 20 clocks with no activity.
- Send 0xA5 (bits LSB first 1,0,1,0,0,1,0,1) → space lengths 4,12,4,12,12,4,12,4, every gap exactly 2 clocks, then ≥4 clocks mark; 82 clocks from the first falling edge to S_ACK.
- Send 0xFF then 0x00 back-to-back, producer re-asserting dav_ as soon as rfd=1 → first byte's pulses all 4 clocks, second byte's all 12 clocks, gap between bytes ≥4 clocks; a receiver instance connected to txd decodes both bytes correctly.
- Hold dav_=0 after the byte completes → rfd stays 0 and txd stays 1 indefinitely; releasing dav_ → rfd=1 on the next edge; no second transmission.
- Change byte_in mid-transmission (0x3C → 0xC3 after the 2nd pulse) → line still carries 0x3C.
- Assert reset_=0 during the 5th pulse → txd=1 and rfd=1 without waiting for a clock edge; after release the next 0x01 is sent correctly (pulses 4 then seven 12-clock pulses).
